// File: rtl/gpio_event_controller_if.sv
// ---------------------------------------------------------------------------
// gpio_event_controller_if
// Clear-request channel of the GPIO event controller.
//   clear_valid : requester wants to clear pending bits
//   clear_mask  : pending bits to clear, qualified by clear_valid
//   clear_ready : controller can accept a clear request this cycle
// A clear is taken on any rising clock edge where clear_valid and
// clear_ready are both high.
// Modports: master (requester side), slave (controller side).
// ---------------------------------------------------------------------------
interface gpio_event_controller_if #(
    parameter int GPIO_WIDTH = 3
) ();
    logic                  clear_valid;
    logic [GPIO_WIDTH-1:0] clear_mask;
    logic                  clear_ready;

    modport master (
        output clear_valid,
        output clear_mask,
        input  clear_ready
    );

    modport slave (
        input  clear_valid,
        input  clear_mask,
        output clear_ready
    );
endinterface

// File: rtl/gpio_event_controller.sv
// ---------------------------------------------------------------------------
// gpio_event_controller
// Synchronises and (optionally) debounces GPIO_WIDTH input pins, latches
// enabled rising/falling level changes into pending bits, and raises a
// registered interrupt while any pending bit is set.
//
// Ports
//   clock       : system clock, all state on its rising edge
//   reset       : asynchronous, active-low reset
//   gpio_input  : raw pin levels, asynchronous to clock
//   rise_en     : per-pin enable for rising-edge events
//   fall_en     : per-pin enable for falling-edge events
//   clr_if      : clear channel (clear_valid / clear_mask / clear_ready)
//   level       : debounced pin levels
//   pending     : latched, enabled edge events
//   irq         : registered OR of pending
//
// Configuration macro
//   GPIO_EVENT_DEBOUNCE_EN : when defined, a level change is accepted only
//   after DEBOUNCE_CYCLES consecutive mismatching cycles. When undefined no
//   counters exist, DEBOUNCE_CYCLES is ignored and level follows the
//   synchronised input every cycle once running.
// ---------------------------------------------------------------------------
module gpio_event_controller #(
    parameter int GPIO_WIDTH      = 3,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [GPIO_WIDTH-1:0]  gpio_input,
    input  logic [GPIO_WIDTH-1:0]  rise_en,
    input  logic [GPIO_WIDTH-1:0]  fall_en,
    gpio_event_controller_if.slave clr_if,
    output logic [GPIO_WIDTH-1:0]  level,
    output logic [GPIO_WIDTH-1:0]  pending,
    output logic                   irq
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // INIT lasts three edges: the third edge after reset release enters RUN.
    localparam logic [1:0]            INIT_LAST = 2'd2;
    localparam logic [GPIO_WIDTH-1:0] ZERO_W    = {GPIO_WIDTH{1'b0}};

    state_e                state_q, state_d;
    logic [1:0]            init_cnt_q, init_cnt_d;
    logic                  clear_ready_q, clear_ready_d;

    logic [GPIO_WIDTH-1:0] sync1_q, sync1_d;
    logic [GPIO_WIDTH-1:0] sync2_q, sync2_d;
    logic [GPIO_WIDTH-1:0] level_q, level_d;
    logic [GPIO_WIDTH-1:0] evt_q, evt_d;
    logic [GPIO_WIDTH-1:0] pending_q, pending_d;
    logic                  irq_q, irq_d;

    // Per pin: mismatch has persisted long enough to be accepted this edge.
    logic [GPIO_WIDTH-1:0] deb_done_s;
    logic [GPIO_WIDTH-1:0] upd_s;
    logic [GPIO_WIDTH-1:0] clr_s;

`ifdef GPIO_EVENT_DEBOUNCE_EN
    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES + 1) > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    logic [CNT_W-1:0] cnt_q [GPIO_WIDTH];
    logic [CNT_W-1:0] cnt_d [GPIO_WIDTH];

    // Debounce counters: count consecutive mismatch cycles, restart on match or acceptance.
    always_comb begin
        for (int i = 0; i < GPIO_WIDTH; i++) begin
            deb_done_s[i] = 1'b0;
            cnt_d[i]      = CNT_ZERO;
            if ((state_q == ST_RUN) && (sync2_q[i] != level_q[i])) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_done_s[i] = 1'b1;
                    cnt_d[i]      = CNT_ZERO;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else begin
                cnt_d[i] = CNT_ZERO;
            end
        end
    end

    // Debounce counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    // Without debouncing every mismatch is accepted immediately.
    assign deb_done_s = {GPIO_WIDTH{1'b1}};

    logic unused_cfg_s;
    assign unused_cfg_s = (DEBOUNCE_CYCLES != 32'sd0);
`endif

    // Mode sequencing: hold INIT for three edges after reset, then stay in RUN.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 2'd1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = 2'd0;
            end
        endcase
        clear_ready_d = (state_d == ST_RUN);
    end

    // Mode state and its registered clear_ready output.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= 2'd0;
            clear_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            clear_ready_q <= clear_ready_d;
        end
    end

    // Synchroniser, level tracking, edge detection, pending and irq next state.
    always_comb begin
        sync1_d = gpio_input;
        sync2_d = sync1_q;

        if (state_q == ST_RUN) begin
            upd_s   = (sync2_q ^ level_q) & deb_done_s;
            level_d = (level_q & ~upd_s) | (sync2_q & upd_s);
        end else begin
            // INIT tracks the pins directly so a pin high at release is not an event.
            upd_s   = ZERO_W;
            level_d = sync2_q;
        end

        // Enables are sampled on the update edge; the event lands in pending one edge later.
        evt_d = upd_s & ((sync2_q & rise_en) | (~sync2_q & fall_en));

        if (clr_if.clear_valid && clear_ready_q) begin
            clr_s = clr_if.clear_mask;
        end else begin
            clr_s = ZERO_W;
        end

        // OR-ing the new events after masking makes a simultaneous set win over clear.
        pending_d = (pending_q & ~clr_s) | evt_q;
        irq_d     = |pending_q;
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= ZERO_W;
            sync2_q   <= ZERO_W;
            level_q   <= ZERO_W;
            evt_q     <= ZERO_W;
            pending_q <= ZERO_W;
            irq_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            evt_q     <= evt_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    assign level              = level_q;
    assign pending            = pending_q;
    assign irq                = irq_q;
    assign clr_if.clear_ready = clear_ready_q;

endmodule

// File: tb/tb_gpio_event_controller.sv
module tb_gpio_event_controller;

    localparam int W = 3;
    localparam int D = 4;
`ifdef GPIO_EVENT_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif
    // Edges from "input changes before edge N" to level update at N+LAT_LVL.
    localparam int LAT_LVL = DEB ? (D + 1) : 2;

    localparam int F_LVL = 0;
    localparam int F_PND = 1;
    localparam int F_IRQ = 2;
    localparam int F_RDY = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] gpio_input;
    logic [W-1:0] rise_en;
    logic [W-1:0] fall_en;
    logic [W-1:0] level;
    logic [W-1:0] pending;
    logic         irq;

    gpio_event_controller_if #(.GPIO_WIDTH(W)) clr_if ();

    gpio_event_controller #(
        .GPIO_WIDTH      (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .gpio_input (gpio_input),
        .rise_en    (rise_en),
        .fall_en    (fall_en),
        .clr_if     (clr_if.slave),
        .level      (level),
        .pending    (pending),
        .irq        (irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        int           edge_no;
        logic [W-1:0] lvl;
        logic [W-1:0] pnd;
        logic         irq_v;
        logic         rdy;
    } exp_t;

    typedef struct {
        int           edge_no;
        int           field;
        logic [W-1:0] val;
        string        name;
    } dir_t;

    exp_t sb_q[$];
    dir_t dir_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: behaviour described by the rules, not the circuit.
    logic [W-1:0] m_s1    = '0;   // input as seen one edge ago
    logic [W-1:0] m_s2    = '0;   // input as seen two edges ago
    logic [W-1:0] m_level = '0;
    logic [W-1:0] m_pend  = '0;
    logic [W-1:0] m_evt   = '0;   // events that land in pending on the next edge
    logic         m_irq   = 1'b0;
    logic         m_ready = 1'b0;
    int           m_edges = 0;    // edges since reset release
    int           m_run[W];       // consecutive cycles the seen input differs from level

    task automatic model_edge();
        logic [W-1:0] nl;
        logic [W-1:0] ne;
        logic [W-1:0] clr;
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_pend = '0; m_evt = '0;
            m_irq = 1'b0; m_ready = 1'b0; m_edges = 0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            clr    = (clr_if.clear_valid && m_ready) ? clr_if.clear_mask : '0;
            m_irq  = |m_pend;
            m_pend = (m_pend & ~clr) | m_evt;
            nl = m_level;
            ne = '0;
            for (int i = 0; i < W; i++) begin
                if (m_edges < 3) begin
                    nl[i] = m_s2[i];
                    m_run[i] = 0;
                end else if (m_s2[i] != m_level[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (!DEB || m_run[i] >= D) begin
                        nl[i] = m_s2[i];
                        m_run[i] = 0;
                        ne[i] = m_s2[i] ? rise_en[i] : fall_en[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_level = nl;
            m_evt   = ne;
            m_s2    = m_s1;
            m_s1    = gpio_input;
            m_edges = m_edges + 1;
            m_ready = (m_edges >= 3);
        end
    endtask

    // One clock: model follows the edge, expected outputs go to the scoreboard.
    task automatic tick();
        @(posedge clock);
        model_edge();
        sb_q.push_back('{m_edges, m_level, m_pend, m_irq, m_ready});
        #1;
    endtask

    task automatic expect_at(input int e, input int f, input logic [W-1:0] v, input string n);
        dir_t d;
        d.edge_no = e;
        d.field   = f;
        d.val     = v;
        d.name    = n;
        dir_q.push_back(d);
    endtask

    task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    initial begin : monitor
        exp_t         e;
        dir_t         d;
        logic [W-1:0] act;
        forever begin
            @(negedge clock);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checks++;
                if (level !== e.lvl || pending !== e.pnd || irq !== e.irq_v ||
                    clr_if.clear_ready !== e.rdy) begin
                    errors++;
                    $display("FAIL cycle edge=%0d: level=%b pending=%b irq=%b ready=%b expected level=%b pending=%b irq=%b ready=%b",
                             e.edge_no, level, pending, irq, clr_if.clear_ready,
                             e.lvl, e.pnd, e.irq_v, e.rdy);
                end
                while (dir_q.size() != 0 && dir_q[0].edge_no == e.edge_no) begin
                    d = dir_q.pop_front();
                    case (d.field)
                        F_LVL:   act = level;
                        F_PND:   act = pending;
                        F_IRQ:   act = W'(irq);
                        default: act = W'(clr_if.clear_ready);
                    endcase
                    checks++;
                    if (act !== d.val) begin
                        errors++;
                        $display("FAIL %s at edge %0d: got %b expected %b", d.name, d.edge_no, act, d.val);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int e;
        gpio_input = '0;
        rise_en = '0;
        fall_en = '0;
        clr_if.clear_valid = 1'b0;
        clr_if.clear_mask = '0;
        reset = 1'b0;
        repeat (3) tick();
        chk("reset_level", level, 3'b000);
        chk("reset_pending", pending, 3'b000);

        // Rising event on pin0, changed before edge 10.
        reset = 1'b1;
        rise_en = 3'b001;
        expect_at(2, F_RDY, 3'b000, "ready_in_init");
        expect_at(3, F_RDY, 3'b001, "ready_in_run");
        expect_at(10 + LAT_LVL - 1, F_LVL, 3'b000, "level_before_latency");
        expect_at(10 + LAT_LVL, F_LVL, 3'b001, "level_rise");
        expect_at(10 + LAT_LVL + 1, F_PND, 3'b001, "pending_rise");
        expect_at(10 + LAT_LVL + 2, F_IRQ, 3'b001, "irq_rise");
        repeat (9) tick();
        gpio_input = 3'b001;
        repeat (LAT_LVL + 6) tick();

        // Pin1 high for three cycles only.
        rise_en = 3'b011;
        fall_en = 3'b000;
        gpio_input = 3'b011;
        repeat (3) tick();
        gpio_input = 3'b001;
        repeat (D + 6) tick();
`ifdef GPIO_EVENT_DEBOUNCE_EN
        expect_at(m_edges + 1, F_LVL, 3'b001, "glitch_level");
        expect_at(m_edges + 1, F_PND, 3'b001, "glitch_pending");
`endif
        tick();

        // Build pending=011 then clear it in two masked steps.
        gpio_input = 3'b011;
        repeat (LAT_LVL + 4) tick();
        expect_at(m_edges + 1, F_PND, 3'b011, "pending_011");
        tick();
        e = m_edges;
        clr_if.clear_valid = 1'b1;
        clr_if.clear_mask = 3'b001;
        expect_at(e + 1, F_PND, 3'b010, "clear_mask_001");
        expect_at(e + 1, F_IRQ, 3'b001, "irq_after_first_clear");
        tick();
        clr_if.clear_valid = 1'b0;
        tick();
        clr_if.clear_valid = 1'b1;
        clr_if.clear_mask = 3'b010;
        expect_at(e + 3, F_PND, 3'b000, "clear_mask_010");
        expect_at(e + 3, F_IRQ, 3'b001, "irq_lags_clear");
        expect_at(e + 4, F_IRQ, 3'b000, "irq_after_second_clear");
        tick();
        clr_if.clear_valid = 1'b0;
        repeat (3) tick();

        // Fall event on pin2 lands on the same edge as a clear of pin2.
        rise_en = 3'b011;
        fall_en = 3'b100;
        gpio_input = 3'b111;
        repeat (LAT_LVL + 4) tick();
        gpio_input = 3'b011;
        repeat (LAT_LVL + 1) tick();
        clr_if.clear_valid = 1'b1;
        clr_if.clear_mask = 3'b100;
        expect_at(m_edges + 1, F_PND, 3'b100, "set_wins_over_clear");
        tick();
        clr_if.clear_valid = 1'b0;
        repeat (2) tick();
        clr_if.clear_valid = 1'b1;
        clr_if.clear_mask = 3'b111;
        tick();
        clr_if.clear_valid = 1'b0;
        tick();

        // Randomised pins (glitches and stable stretches), enables and clears.
        repeat (1500) begin
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 7) == 0) gpio_input[i] = ~gpio_input[i];
            end
            if ($urandom_range(0, 63) == 0) rise_en = W'($urandom);
            if ($urandom_range(0, 63) == 0) fall_en = W'($urandom);
            clr_if.clear_valid = ($urandom_range(0, 9) == 0);
            clr_if.clear_mask = W'($urandom);
            tick();
        end
        clr_if.clear_valid = 1'b0;

        // Pins high through reset release: level comes up in INIT with no events.
        #6;
        reset = 1'b0;
        gpio_input = 3'b111;
        rise_en = 3'b111;
        fall_en = 3'b111;
        repeat (2) tick();
        reset = 1'b1;
        expect_at(3, F_LVL, 3'b111, "init_level_high");
        expect_at(3, F_PND, 3'b000, "init_no_pending");
        expect_at(4, F_IRQ, 3'b000, "init_no_irq");
        expect_at(5, F_PND, 3'b000, "init_no_pending_late");
        expect_at(5, F_IRQ, 3'b000, "init_no_irq_late");
        repeat (8) tick();

        // Reset pulsed mid-debounce with a pending bit set.
        gpio_input = 3'b011;
        repeat (LAT_LVL + 3) tick();
        gpio_input = 3'b111;
        repeat (2) tick();
        #6;
        reset = 1'b0;
        #1;
        chk("async_reset_level", level, 3'b000);
        chk("async_reset_pending", pending, 3'b000);
        chk("async_reset_irq", W'(irq), 3'b000);
        chk("async_reset_ready", W'(clr_if.clear_ready), 3'b000);
        repeat (2) tick();
        reset = 1'b1;
        repeat (6) tick();

        @(negedge clock);
        #1;
        while (dir_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: edge %0d never reached", dir_q[0].name, dir_q[0].edge_no);
            void'(dir_q.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_event_controller.md
GPIO_EVENT_CONTROLLER -- requirements
Module: gpio_event_controller

Interface
REQ-001 SHALL have parameter GPIO_WIDTH, default 3: number of GPIO pins monitored.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 120000: consecutive stable cycles required to accept a level change (10 ms at 12 MHz); legal range 1..2^24.
REQ-003 SHALL have port clock  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port gpio_input  input  GPIO_WIDTH  raw pin levels, asynchronous to clock.
REQ-006 SHALL have port rise_en  input  GPIO_WIDTH  per-pin enable for rising-edge events.
REQ-007 SHALL have port fall_en  input  GPIO_WIDTH  per-pin enable for falling-edge events.
REQ-008 SHALL have port clear_valid  input  1  request to clear pending bits.
REQ-009 SHALL have port clear_mask  input  GPIO_WIDTH  pending bits to clear; sampled with clear_valid.
REQ-010 SHALL have port clear_ready  output  1  controller can accept a clear request.
REQ-011 SHALL have port level  output  GPIO_WIDTH  debounced pin levels.
REQ-012 SHALL have port pending  output  GPIO_WIDTH  latched, enabled edge events.
REQ-013 SHALL have port irq  output  1  registered OR of pending.

Function
REQ-014 SHALL pass each gpio_input bit through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-015 SHALL run a two-state FSM, INIT and RUN; INIT on reset, RUN after exactly 3 clock edges following reset deassertion.
REQ-016 In INIT, level SHALL load sync2 every cycle; debounce counters held at 0; no edges flagged; clear_ready = 0.
REQ-017 In RUN, clear_ready SHALL be 1; a clear is accepted on any edge where clear_valid and clear_ready are both 1.
REQ-018 Per pin in RUN: sync2 == level -> counter = 0; otherwise counter increments, and on the edge where counter == DEBOUNCE_CYCLES-1, level <= sync2 and counter <= 0.
REQ-019 A mismatch that disappears before DEBOUNCE_CYCLES consecutive cycles SHALL reset the counter and leave level unchanged (glitch rejected).
REQ-020 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1), minimum 1; the counter never wraps.
REQ-021 A level 0->1 update with rise_en set, or 1->0 with fall_en set, SHALL set the pin's pending bit on the next edge.
REQ-022 Enables are sampled on the level-update cycle; clearing an enable does not clear an existing pending bit.
REQ-023 An accepted clear SHALL clear pending bits where clear_mask = 1 on the next edge; unmasked bits are unaffected.
REQ-024 Set and clear of the same bit on the same edge: set SHALL win (bit stays 1).
REQ-025 irq SHALL be registered: irq at edge k+1 equals |pending at edge k.
REQ-026 Latency: a pin change settling before edge N SHALL appear on level at edge N+1+DEBOUNCE_CYCLES, on pending at N+2+DEBOUNCE_CYCLES, and on irq at N+3+DEBOUNCE_CYCLES.

Reset
REQ-027 While reset = 0: sync1, sync2, level, pending, counters = 0; irq = 0; clear_ready = 0; FSM = INIT.
REQ-028 Reset asserted mid-debounce or with pending set SHALL discard all state immediately and without a clock.
REQ-029 A pin that is high at reset release SHALL reach level = 1 during INIT without setting pending.

Configuration
REQ-030 Macro GPIO_EVENT_DEBOUNCE_EN SHALL select debouncing: if defined, REQ-018..020 apply.
REQ-031 If GPIO_EVENT_DEBOUNCE_EN is undefined, counters SHALL NOT be instantiated, DEBOUNCE_CYCLES is ignored, and in RUN level <= sync2 every cycle (level at N+2, pending at N+3, irq at N+4).

Verification
REQ-032 Debounce on, DEBOUNCE_CYCLES=4, rise_en=3'b001, pin0 0->1 before edge 10 -> level[0]=1 at 15, pending=3'b001 at 16, irq=1 at 17.
REQ-033 Debounce on, DEBOUNCE_CYCLES=4, pin1 high for 3 cycles then low -> level, pending and irq remain 0.
REQ-034 pending=3'b011; clear_valid=1 with clear_mask=3'b001 for one cycle -> pending=3'b010 next edge, irq stays 1; second clear with mask 3'b010 -> pending=0, irq=0 one edge later.
REQ-035 A fall event on pin2 (fall_en[2]=1) completes on the same edge as an accepted clear with clear_mask=3'b100 -> pending[2]=1.
REQ-036 gpio_input=3'b111 held through reset release -> level=3'b111 by end of INIT, pending=0, irq=0; reset pulsed low mid-debounce -> all outputs 0 asynchronously.
REQ-037 Macro undefined, pin0 0->1 before edge 10 with rise_en[0]=1 -> level[0]=1 at 12, pending[0]=1 at 13, irq=1 at 14.
